// File: rtl/lcd_char_driver.sv
// rtl/lcd_char_driver.sv - HD44780 8-bit character display refresh driver
// Ports:
//   CLK          in   single clock
//   RST_N        in   synchronous active-low reset
//   FRAME        in   ROWS*COLS character codes, row 0 col 0 in the MSB byte, row-major
//   FRAME_VALID  in   FRAME holds a new frame
//   FRAME_READY  out  shadow buffer empty, FRAME accepted on FRAME_VALID
//   FRAME_DONE   out  one-cycle pulse after the last character of the last row
//   LCD_E        out  registered HD44780 enable
//   LCD_RS       out  0 command, 1 data
//   LCD_DATA     out  HD44780 8-bit data bus
module lcd_char_driver #(
  parameter int          TIME_PWRUP = 1_000_000,
  parameter int          TIME_TICK  = 100_000,
  parameter int          ROWS       = 2,
  parameter int          COLS       = 16,
  parameter logic [7:0]  DISP_CTRL  = 8'h0C
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [ROWS*COLS*8-1:0]   FRAME,
  input  logic                     FRAME_VALID,
  output logic                     FRAME_READY,
  output logic                     FRAME_DONE,
  output logic                     LCD_E,
  output logic                     LCD_RS,
  output logic [7:0]               LCD_DATA
);

  localparam int NCH  = ROWS * COLS;
  localparam int FW   = NCH * 8;
  localparam int PW_W = (TIME_PWRUP > 1) ? $clog2(TIME_PWRUP) : 1;
  localparam int TK_W = $clog2(TIME_TICK);

  localparam logic [PW_W-1:0] PW_LAST  = PW_W'(TIME_PWRUP - 1);
  localparam logic [TK_W-1:0] TK_LAST  = TK_W'(TIME_TICK - 1);
  localparam logic [TK_W-1:0] TK_HALF  = TK_W'(TIME_TICK / 2);
  localparam logic [4:0]      COL_LAST = 5'(COLS - 1);
  localparam logic [1:0]      ROW_LAST = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    PWRUP, INIT0, INIT1, INIT2, INIT3, INIT4, ADDR, CHAR
  } state_e;

  state_e            state_q, state_d;
  logic [PW_W-1:0]   pwrup_cnt_q, pwrup_cnt_d;
  logic [TK_W-1:0]   tick_q, tick_d;
  logic [1:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [FW-1:0]     active_q, active_d;
  logic              done_q, done_d;
  logic              e_q, e_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;

  logic              strobe;
  logic              pwrup_done;
  logic              last_char;
  logic              enter_row0;
  logic              copy;
  logic              accept;
  logic [6:0]        lin;
  logic [7:0]        char_byte;

  function automatic logic [7:0] row_addr(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h80;
      2'd1:    return 8'hC0;
      2'd2:    return 8'h80 + 8'(COLS);
      default: return 8'hC0 + 8'(COLS);
    endcase
  endfunction

  assign strobe     = (state_q != PWRUP) && (tick_q == TK_LAST);
  assign pwrup_done = (state_q == PWRUP) && (pwrup_cnt_q == PW_LAST);
  assign last_char  = strobe && (state_q == CHAR) && (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign enter_row0 = (strobe && (state_q == INIT4)) || last_char;
  assign copy       = enter_row0 && shadow_full_q;
  // A frame offered on the copy cycle lands in the slot being vacated, even
  // though FRAME_READY (registered) still shows 0 during that cycle.
  assign accept     = FRAME_VALID && (!shadow_full_q || copy);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= PWRUP;
      pwrup_cnt_q   <= '0;
      tick_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= {NCH{8'h20}};
      done_q        <= 1'b0;
      e_q           <= 1'b0;
      rs_q          <= 1'b0;
      data_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      pwrup_cnt_q   <= pwrup_cnt_d;
      tick_q        <= tick_d;
      row_q         <= row_d;
      col_q         <= col_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      done_q        <= done_d;
      e_q           <= e_d;
      rs_q          <= rs_d;
      data_q        <= data_d;
    end
  end

  // Next state and cursor position; row_d/col_d name the slot being entered
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      PWRUP: if (pwrup_done) state_d = INIT0;
      INIT0: if (strobe) state_d = INIT1;
      INIT1: if (strobe) state_d = INIT2;
      INIT2: if (strobe) state_d = INIT3;
      INIT3: if (strobe) state_d = INIT4;
      INIT4: begin
        if (strobe) begin
          state_d = ADDR;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ADDR: begin
        if (strobe) begin
          state_d = CHAR;
          col_d   = '0;
        end
      end
      CHAR: begin
        if (strobe) begin
          if (col_q == COL_LAST) begin
            state_d = ADDR;
            col_d   = '0;
            row_d   = (row_q == ROW_LAST) ? 2'd0 : row_q + 2'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  // Character for the slot being entered, read from the current active buffer
  always_comb begin
    lin       = 7'(row_d) * 7'(COLS) + 7'(col_d);
    char_byte = 8'h20;
    for (int i = 0; i < NCH; i++) begin
      if (lin == 7'(i)) char_byte = active_q[8*(NCH-1-i) +: 8];
    end
  end

  // Counters, buffers and bus outputs
  always_comb begin
    pwrup_cnt_d   = (pwrup_cnt_q == PW_LAST) ? pwrup_cnt_q : pwrup_cnt_q + PW_W'(1);
    tick_d        = ((state_q == PWRUP) || strobe) ? '0 : tick_q + TK_W'(1);
    shadow_d      = accept ? FRAME : shadow_q;
    shadow_full_d = accept || (shadow_full_q && !copy);
    active_d      = copy ? shadow_q : active_q;
    done_d        = last_char;
    // Enable is registered, so derive it from the next tick/state
    e_d           = (state_d != PWRUP) && (tick_d < TK_HALF);
    rs_d          = rs_q;
    data_d        = data_q;
    // Leaving power-up acts as the first write slot boundary
    if (pwrup_done) begin
      rs_d   = 1'b0;
      data_d = 8'h38;
    end else if (strobe) begin
      case (state_q)
        INIT0: begin rs_d = 1'b0; data_d = 8'h08;        end
        INIT1: begin rs_d = 1'b0; data_d = 8'h01;        end
        INIT2: begin rs_d = 1'b0; data_d = 8'h06;        end
        INIT3: begin rs_d = 1'b0; data_d = DISP_CTRL;    end
        INIT4: begin rs_d = 1'b0; data_d = row_addr(2'd0); end
        ADDR:  begin rs_d = 1'b1; data_d = char_byte;    end
        CHAR: begin
          if (col_q == COL_LAST) begin
            rs_d   = 1'b0;
            data_d = row_addr(row_d);
          end else begin
            rs_d   = 1'b1;
            data_d = char_byte;
          end
        end
        default: begin rs_d = rs_q; data_d = data_q; end
      endcase
    end
  end

  assign FRAME_READY = !shadow_full_q;
  assign FRAME_DONE  = done_q;
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_DATA    = data_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// tb/tb_lcd_char_driver.sv - scoreboard bench for lcd_char_driver
module tb_lcd_char_driver;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  frame = '0;
  logic         frame_valid = 1'b0;
  logic         frame_ready, frame_done, lcd_e, lcd_rs;
  logic [7:0]   lcd_data;

  logic         rst4_n = 1'b0;
  logic [639:0] frame4 = '0;
  logic         valid4 = 1'b0;
  logic         ready4, done4, e4, rs4;
  logic [7:0]   data4;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [9:0]   exp_q[$];
  logic [9:0]   exp_item;

  always #5 clk = ~clk;

  lcd_char_driver #(.TIME_PWRUP(10), .TIME_TICK(4), .ROWS(2), .COLS(4), .DISP_CTRL(8'h0C)) u_dut (
    .CLK(clk), .RST_N(rst_n), .FRAME(frame), .FRAME_VALID(frame_valid),
    .FRAME_READY(frame_ready), .FRAME_DONE(frame_done),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_DATA(lcd_data)
  );

  lcd_char_driver #(.TIME_PWRUP(10), .TIME_TICK(4), .ROWS(4), .COLS(20), .DISP_CTRL(8'h0C)) u_dut4 (
    .CLK(clk), .RST_N(rst4_n), .FRAME(frame4), .FRAME_VALID(valid4),
    .FRAME_READY(ready4), .FRAME_DONE(done4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_DATA(data4)
  );

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    for (int i = 0; i < 4000 && cyc < k; i++) @(negedge clk);
    if (cyc < k) chk("wait_cyc", 32'(cyc), 32'(k));
  endtask

  task automatic push_init();
    logic [7:0] ic [5];
    ic = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    for (int i = 0; i < 5; i++) exp_q.push_back({2'b00, ic[i]});
  endtask

  task automatic push_pass(input logic [63:0] f, input bit fd);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({(fd && r == 0), 1'b0, (r == 0) ? 8'h80 : 8'hC0});
      for (int c = 0; c < 4; c++) exp_q.push_back({2'b01, f[63-8*(r*4+c) -: 8]});
    end
  endtask

  // Called at a negedge; returns at the negedge after the 10th power-up cycle
  task automatic reset_pwrup(input bit v_in_rst, input bit preload, input logic [63:0] f);
    rst_n = 1'b0;
    frame = f;
    frame_valid = v_in_rst;
    @(negedge clk);
    rst_n = 1'b1;
    frame_valid = 1'b0;
    push_init();
    chk("rst_ready", 32'(frame_ready), 1);
    chk("rst_rs_data", 32'({lcd_rs, lcd_data}), 0);
    chk("rst_done", 32'(frame_done), 0);
    for (int i = 0; i < 10; i++) begin
      chk("pwrup_e", 32'(lcd_e), 0);
      if (preload && i == 2) begin
        chk("pwrup_ready", 32'(frame_ready), 1);
        frame = f;
        frame_valid = 1'b1;
      end
      if (preload && i == 3) begin
        frame_valid = 1'b0;
        chk("preload_ready", 32'(frame_ready), 0);
      end
      @(negedge clk);
    end
  endtask

  // Slot monitor for the 2x4 instance: each rising LCD_E starts a write slot
  initial begin
    logic e_prev, fd_prev;
    e_prev = 1'b0;
    fd_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (lcd_e && !e_prev && exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        chk("slot", 32'({frame_done, lcd_rs, lcd_data}), 32'(exp_item));
      end
      if (frame_done) chk("fd_width", 32'(fd_prev), 0);
      e_prev = lcd_e;
      fd_prev = frame_done;
    end
  end

  // Slot monitor for the 4x20 instance
  int n_fd4 = 0;
  initial begin
    logic       e_prev;
    logic [7:0] a4 [4];
    int         a4_idx, slots4;
    a4 = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    a4_idx = 0;
    slots4 = 0;
    e_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (e4 && !e_prev) begin
        slots4++;
        if (!rs4 && data4[7]) begin
          chk("addr4", 32'(data4), 32'(a4[a4_idx]));
          a4_idx = (a4_idx + 1) % 4;
        end
        if (rs4) chk("char4", 32'(data4), 32'h20);
        if (done4) begin
          if (n_fd4 == 0) chk("fd4_first", 32'(slots4), 90);
          else            chk("fd4_period", 32'(slots4), 84);
          n_fd4++;
          slots4 = 0;
        end
      end
      e_prev = e4;
    end
  end

  initial begin
    logic [63:0] fa, fx, fy, fw, blank;
    fa = "ABCDEFGH";
    fx = "IJKLMNOP";
    fy = "QRSTUVWX";
    fw = "wwwwwwww";
    blank = {8{8'h20}};
    repeat (2) @(negedge clk);
    chk("ready4_rst", 32'(ready4), 1);
    rst4_n = 1'b1;

    // No frame: init sequence then a blank pass
    reset_pwrup(1'b0, 1'b0, blank);
    push_pass(blank, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 8'h80});
    wait_cyc(72);
    chk("q_empty_1", 32'(exp_q.size()), 0);

    // Preload during power-up, then X mid-row and Y held through the copy
    reset_pwrup(1'b0, 1'b1, fa);
    push_pass(fa, 1'b0);
    push_pass(fa, 1'b1);
    push_pass(fx, 1'b1);
    push_pass(fy, 1'b1);
    exp_q.push_back({1'b1, 1'b0, 8'h80});
    wait_cyc(29);
    chk("ready_before_copy", 32'(frame_ready), 0);
    wait_cyc(30);
    chk("ready_after_copy", 32'(frame_ready), 1);
    wait_cyc(80);
    frame = fx;
    frame_valid = 1'b1;
    wait_cyc(81);
    frame_valid = 1'b0;
    chk("x_taken", 32'(frame_ready), 0);
    wait_cyc(82);
    frame = fy;
    frame_valid = 1'b1;
    wait_cyc(109);
    chk("y_blocked", 32'(frame_ready), 0);
    wait_cyc(110);
    frame_valid = 1'b0;
    chk("copy_and_take", 32'(frame_ready), 0);
    wait_cyc(149);
    chk("y_pending", 32'(frame_ready), 0);
    wait_cyc(150);
    chk("y_copied", 32'(frame_ready), 1);
    wait_cyc(191);
    chk("q_empty_2", 32'(exp_q.size()), 0);

    // Reset pulse in CHAR (1,2) with a frame offered in the reset cycle
    wait_cyc(222);
    chk("pre_rst_e", 32'(lcd_e), 1);
    reset_pwrup(1'b1, 1'b0, fw);
    push_pass(blank, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 8'h80});
    wait_cyc(72);
    chk("q_empty_3", 32'(exp_q.size()), 0);

    for (int i = 0; i < 2000 && n_fd4 < 3; i++) @(negedge clk);
    chk("fd4_count", 32'(n_fd4 >= 3), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
